fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the PC, issues in-order requests on a valid/ready instruction-memory port, and buffers responses in a small FIFO.
- Drives the IF/ID register consumed by decode.
- Takes stall from the hazard unit and branch/jump redirect from execute; discards in-flight responses that a redirect has killed.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC after reset.
- FIFO_DEPTH, 2, response buffer entries; also the maximum number of outstanding requests. Power of two, ≥2.
- NOP_INSTR, 32'h0000_0013, instruction word driven while decode is invalid (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. Responses are in order, at least 1 cycle after acceptance, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- stall_d  in  1  hold the IF/ID register (hazard unit).
- pcsrc_e  in  1  redirect/flush (taken branch or jump in EX).
- pctarget_e  in  XLEN  redirect target.
- valid_d  out  1  IF/ID holds a real instruction.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  XLEN  IF/ID PC.
- pcplus4_d  out  XLEN  IF/ID PC+4.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_f=RESET_PC, deliver_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, FIFO empty.
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0.
  - imem_req_valid=0 while rst=0.
- Internal state:
  - pc_f: next address to request.
  - deliver_pc: PC of the FIFO head.
  - outstanding: accepted requests not yet answered, 0..FIFO_DEPTH.
  - drop_cnt: responses still to discard.
  - FIFO of instruction words.
- Definitions:
  - pop = !pcsrc_e & !stall_d & fifo_not_empty.
  - fire = imem_req_valid & imem_req_ready.
- Request issue:
  - imem_req_valid = rst & !pcsrc_e & (outstanding + fifo_count - pop < FIFO_DEPTH).
  - Combinational path from stall_d/pcsrc_e to imem_req_valid is allowed.
  - imem_req_addr = pc_f.
  - On fire: pc_f += 4 (mod 2^XLEN, wraps silently) and outstanding++.
  - imem_req_addr must stay stable while valid & !ready, except when a redirect changes it.
- Response:
  - On imem_rsp_valid, outstanding--.
  - If drop_cnt>0: discard, drop_cnt--.
  - Otherwise push into the FIFO. Overflow is impossible by credit; assert it.
- IF/ID update, priority pcsrc_e > stall_d > normal:
  - pcsrc_e=1: valid_d<=0, instr_d<=NOP_INSTR. FIFO cleared, pc_f<=pctarget_e, deliver_pc<=pctarget_e. drop_cnt<=outstanding+(fire?1:0)-(rsp_valid?1:0); fire is 0 by construction. No issue this cycle. A response in the same cycle is discarded. Issue resumes next cycle.
  - stall_d=1: all IF/ID outputs hold. No pop. Pushes and issues continue within credit.
  - Normal, FIFO not empty: instr_d<=head, pc_d<=deliver_pc, pcplus4_d<=deliver_pc+4, valid_d<=1, pop, deliver_pc+=4.
  - Normal, FIFO empty: bubble. valid_d<=0, instr_d<=NOP_INSTR; pc_d/pcplus4_d hold.
- Timing:
  - No FIFO bypass: a response reaches IF/ID one edge after its push.
  - With a 1-cycle memory and ready=1: first valid_d is seen after the 3rd rising edge following rst release, then 1 instruction/cycle sustained.
- Simultaneous push and pop on the FIFO: both occur and count is unchanged.
- Reset mid-operation: all state is cleared immediately. The memory subsystem shares the reset, so no stale responses arrive.
- Misaligned pctarget_e: bits [1:0] forced to 0.

Decomposition:
- Shared package rv_pkg holds XLEN, NOP_INSTR (32'h0000_0013), RESET_PC default, and the FIFO_DEPTH default.
- One sub-module, fetch_fifo: synchronous FIFO with clear, push/pop, count, empty/full, and asynchronous active-low reset.
- Credit logic, PC, drop counter and the IF/ID register stay in fetch_stage.

Test Plan:
- Reset, then release with imem 1-cycle latency and ready=1, memory returning word=addr:
  - After the 3rd edge, valid_d=1, pc_d=0x0, instr_d=0x0.
  - Next cycles show pc_d=0x4, 0x8, 0xC with one instruction per cycle and no bubbles.
- stall_d high for 3 cycles while pc_d=0x8:
  - Outputs hold 0x8 for all 3 cycles.
  - Outstanding+FIFO never exceeds 2.
  - After release, pc_d=0xC next with no gap and no duplicate.
- pcsrc_e=1 with pctarget_e=0x100 while 1 request is outstanding and 1 FIFO entry is held:
  - Next cycle valid_d=0.
  - The stale response is discarded.
  - First valid after the redirect has pc_d=0x100, pcplus4_d=0x104.
- imem_req_ready low for 4 cycles:
  - imem_req_addr is held stable.
  - valid_d drains to 0 and restarts in order with no skipped PC.
- Memory latency 3 cycles: at most FIFO_DEPTH=2 requests are outstanding, and the delivered PC sequence is contiguous.
- rst asserted mid-stream:
  - All outputs return to reset values asynchronously.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants for the RV32I pipeline slice.
// Holds the default datapath width, reset PC, NOP encoding and fetch
// buffer depth used by fetch_stage and fetch_fifo.
package rv_pkg;

  localparam int unsigned RV_XLEN       = 32;
  localparam int unsigned RV_INSTR_W    = 32;
  localparam logic [31:0] RV_RESET_PC   = 32'h0000_0000;
  localparam int unsigned RV_FIFO_DEPTH = 2;
  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering instruction-memory responses for the IF stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             synchronous flush of all entries (wins over push)
//   push_i, data_i      write one word
//   pop_i               drop the head word
//   data_o              head word (valid when !empty_o)
//   count_o             number of held entries, 0..DEPTH
//   empty_o, full_o     occupancy flags
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = RV_INSTR_W,
  parameter int unsigned DEPTH = RV_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline.
// Owns the PC, issues in-order requests on a valid/ready instruction-memory
// port, buffers responses in fetch_fifo and drives the IF/ID register.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr  request channel (addr word aligned)
//   imem_rsp_valid/data        in-order response channel, never stalled
//   stall_d                    hold IF/ID (hazard unit)
//   pcsrc_e, pctarget_e        redirect from execute, flushes IF/ID
//   valid_d, instr_d, pc_d, pcplus4_d   IF/ID register
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN       = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RV_RESET_PC),
  parameter int unsigned     FIFO_DEPTH = RV_FIFO_DEPTH,
  parameter logic [31:0]     NOP_INSTR  = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall_d,
  input  logic            pcsrc_e,
  input  logic [XLEN-1:0] pctarget_e,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d
);

  localparam int unsigned     CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     SUM_W   = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]  pc_f_q, pc_f_d;
  logic [XLEN-1:0]  deliver_pc_q, deliver_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0]  ifid_pcplus4_q, ifid_pcplus4_d;

  logic             fifo_push, fifo_pop, fifo_clear;
  logic [31:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;

  logic [SUM_W-1:0] in_flight;
  logic             req_valid, fire, dropping;
  logic [XLEN-1:0]  target_aligned;

  assign target_aligned = pctarget_e & ~XLEN'(3);
  assign dropping       = (drop_cnt_q != '0);

  // Credit: every accepted request owns a FIFO slot until it is consumed;
  // a pop in this cycle frees its slot early so fetch sustains 1/cycle.
  assign fifo_pop   = !pcsrc_e && !stall_d && !fifo_empty;
  assign in_flight  = SUM_W'(outstanding_q) + SUM_W'(fifo_count) - SUM_W'(fifo_pop);
  assign req_valid  = rst && !pcsrc_e && (in_flight < DEPTH_S);
  assign fire       = req_valid && imem_req_ready;
  assign fifo_push  = imem_rsp_valid && !dropping && !pcsrc_e;
  assign fifo_clear = pcsrc_e;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_f_q;

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .data_i  (imem_rsp_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Outstanding count, drop counter and PCs.
  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    pc_f_d        = pc_f_q;
    deliver_pc_d  = deliver_pc_q;
    if (pcsrc_e) begin
      // Everything still in flight after this edge belongs to the killed path.
      drop_cnt_d   = outstanding_d;
      pc_f_d       = target_aligned;
      deliver_pc_d = target_aligned;
    end else begin
      if (imem_rsp_valid && dropping) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (fire)     pc_f_d       = pc_f_q + PC_STEP;
      if (fifo_pop) deliver_pc_d = deliver_pc_q + PC_STEP;
    end
  end

  // IF/ID register: redirect > stall > normal.
  always_comb begin
    ifid_valid_d   = ifid_valid_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pcplus4_d = ifid_pcplus4_q;
    if (pcsrc_e) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall_d) begin
      if (!fifo_empty) begin
        ifid_valid_d   = 1'b1;
        ifid_instr_d   = fifo_head;
        ifid_pc_d      = deliver_pc_q;
        ifid_pcplus4_d = deliver_pc_q + PC_STEP;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f_q         <= RESET_PC;
      deliver_pc_q   <= RESET_PC;
      outstanding_q  <= '0;
      drop_cnt_q     <= '0;
      ifid_valid_q   <= 1'b0;
      ifid_instr_q   <= NOP_INSTR;
      ifid_pc_q      <= '0;
      ifid_pcplus4_q <= '0;
    end else begin
      pc_f_q         <= pc_f_d;
      deliver_pc_q   <= deliver_pc_d;
      outstanding_q  <= outstanding_d;
      drop_cnt_q     <= drop_cnt_d;
      ifid_valid_q   <= ifid_valid_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
    end
  end

  assign valid_d   = ifid_valid_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pcplus4_d = ifid_pcplus4_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && fifo_full && !fifo_pop));
  a_rsp_expected : assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a queue-based reference model and
// an in-order instruction memory model returning word = addr ^ key.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_d, pcsrc_e;
  logic [31:0] pctarget_e;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pcplus4_d;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_d        (stall_d),
    .pcsrc_e        (pcsrc_e),
    .pctarget_e     (pctarget_e),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pcplus4_d      (pcplus4_d)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: requests in memory, buffered addresses, IF/ID contents.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          killed;
  } req_t;

  req_t        mq[$];
  logic [31:0] fq[$];
  logic [31:0] m_pcf;
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_pc4;
  logic [31:0] key = 32'h0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          mem_pause = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic model_reset();
    mq.delete();
    fq.delete();
    m_pcf   = 32'h0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc    = 32'h0;
    m_pc4   = 32'h0;
  endtask

  // Called at a falling edge: check IF/ID, drive one cycle, advance model.
  task automatic step(input bit st, input bit br, input logic [31:0] tgt, input bit rdy);
    bit          pop, exp_rv, fire, rsp, rsp_killed;
    logic [31:0] rsp_addr, a;
    int unsigned fill;
    req_t        r;
    chk("valid_d", 32'(valid_d), 32'(m_valid));
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pc);
    chk("pcplus4_d", pcplus4_d, m_pc4);
    stall_d        = st;
    pcsrc_e        = br;
    pctarget_e     = tgt;
    imem_req_ready = rdy;
    rsp        = !mem_pause && (mq.size() > 0) && (mq[0].due <= cyc);
    rsp_addr   = 32'h0;
    rsp_killed = 1'b0;
    if (rsp) begin
      rsp_addr   = mq[0].addr;
      rsp_killed = mq[0].killed;
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
    #1;
    pop    = !br && !st && (fq.size() > 0);
    fill   = mq.size() + fq.size() - (pop ? 1 : 0);
    exp_rv = !br && (fill < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pcf);
    fire = exp_rv && rdy;
    if (rsp) void'(mq.pop_front());
    if (br) begin
      foreach (mq[i]) mq[i].killed = 1'b1;
      fq.delete();
      m_pcf   = {tgt[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = NOP;
    end else begin
      if (!st) begin
        if (fq.size() > 0) begin
          a       = fq.pop_front();
          m_valid = 1'b1;
          m_instr = mem_word(a);
          m_pc    = a;
          m_pc4   = a + 32'd4;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end
      if (rsp && !rsp_killed) fq.push_back(rsp_addr);
      if (fire) begin
        r.addr   = m_pcf;
        r.due    = cyc + $urandom_range(lat_max, lat_min);
        r.killed = 1'b0;
        mq.push_back(r);
        m_pcf = m_pcf + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_steps(input int unsigned n);
    logic [31:0] tgt;
    for (int unsigned i = 0; i < n; i++) begin
      mem_pause = ($urandom_range(9, 0) == 0);
      tgt = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'hFFFF);
      step($urandom_range(3, 0) == 0, $urandom_range(11, 0) == 0, tgt,
           $urandom_range(3, 0) != 0);
    end
    mem_pause = 1'b0;
  endtask

  // Startup sequence with a 1-cycle memory: first instruction after 3 edges.
  task automatic startup_checks(input logic [31:0] k);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("boot_no_valid_e2", 32'(valid_d), 32'd0);
    step(0, 0, 0, 1);
    chk("boot_valid_e3", 32'(valid_d), 32'd1);
    chk("boot_pc_e3", pc_d, 32'h0);
    chk("boot_instr_e3", instr_d, k);
    step(0, 0, 0, 1);
    chk("boot_pc_e4", pc_d, 32'h4);
    step(0, 0, 0, 1);
    chk("boot_pc_e5", pc_d, 32'h8);
  endtask

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    stall_d        = 1'b0;
    pcsrc_e        = 1'b0;
    pctarget_e     = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;

    startup_checks(32'h0);

    // Stall while pc_d = 0x8, then resume at 0xC.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      chk("stall_hold_pc", pc_d, 32'h8);
      chk("stall_hold_valid", 32'(valid_d), 32'd1);
    end
    step(0, 0, 0, 1);
    chk("stall_release_pc", pc_d, 32'hC);

    // Redirect with one request outstanding and one FIFO entry; the memory
    // holds the stale response back one cycle so it must be dropped.
    mem_pause = 1'b1;
    step(0, 1, 32'h0000_0102, 1);
    mem_pause = 1'b0;
    chk("redir_bubble", 32'(valid_d), 32'd0);
    for (int i = 0; i < 10 && !valid_d; i++) step(0, 0, 0, 1);
    chk("redir_valid", 32'(valid_d), 32'd1);
    chk("redir_pc", pc_d, 32'h100);
    chk("redir_pcplus4", pcplus4_d, 32'h104);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Memory not ready for 4 cycles: drain, then in-order restart.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("ready_low_drained", 32'(valid_d), 32'd0);
    repeat (6) step(0, 0, 0, 1);

    // 3-cycle memory latency.
    lat_min = 3;
    lat_max = 3;
    repeat (30) step(0, 0, 0, 1);

    // Random traffic with variable latency.
    lat_min = 1;
    lat_max = 4;
    rand_steps(400);

    // Asynchronous reset mid-stream.
    #2;
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_d), 32'd0);
    chk("arst_instr", instr_d, NOP);
    chk("arst_pc", pc_d, 32'h0);
    chk("arst_pcplus4", pcplus4_d, 32'h0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    model_reset();
    key = 32'h5A5A_0000;
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_req_valid", 32'(imem_req_valid), 32'd0);
    rst     = 1'b1;
    lat_min = 1;
    lat_max = 1;
    startup_checks(32'h5A5A_0000);

    lat_max = 3;
    rand_steps(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
